// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution engine.
// Result reduction is selected by CONV_SAT_EN (saturate) vs. default wrap.
package conv_pkg;

    localparam int FRAC_BITS = 7;
    localparam int TAPS      = 9;

    typedef logic signed [7:0]  pixel_t;
    typedef logic signed [7:0]  coef_t;
    typedef logic signed [19:0] acc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    // Tap index k = ky*3 + kx
    function automatic logic [1:0] tap_ky(input logic [3:0] t);
        if (t >= 4'd6) return 2'd2;
        if (t >= 4'd3) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] tap_kx(input logic [3:0] t);
        logic [3:0] m;
        m = t - 4'(3 * tap_ky(t));
        return m[1:0];
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed 8x8 multiply feeding a 20-bit accumulator with synchronous clear.
module conv_mac
    import conv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   en,
    input  pixel_t pix,
    input  coef_t  coef,
    output acc_t   acc
);

    logic signed [15:0] prod;
    acc_t acc_d, acc_q;

    always_comb begin
        prod  = 16'(pix) * 16'(coef);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + acc_t'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: fetches each window tap-by-tap and streams results.
// Define CONV_SAT_EN to saturate results instead of wrapping.
module conv3x3_engine
    import conv_pkg::*;
#(
    parameter  int IMG_DIM = 8,
    localparam int AW      = 2 * $clog2(IMG_DIM),
    localparam int CW      = $clog2(IMG_DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          kwr,
    input  logic [3:0]    kaddr,
    input  logic [7:0]    kdin,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col
);

    localparam logic [CW-1:0] LAST = CW'(IMG_DIM - 3);

    state_t          state_d, state_q;
    logic [3:0]      tap_d, tap_q;
    logic [3:0]      rtap_d, rtap_q;
    logic            rd_d, rd_q;
    logic [CW-1:0]   r_d, r_q;
    logic [CW-1:0]   c_d, c_q;
    coef_t           coef_d [TAPS];
    coef_t           coef_q [TAPS];
    logic            clr;
    logic [CW-1:0]   row_a, col_a;
    acc_t            acc;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        r_d     = r_q;
        c_d     = c_q;
        coef_d  = coef_q;
        mem_rd  = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    tap_d   = '0;
                    r_d     = '0;
                    c_d     = '0;
                end
                if (kwr && kaddr < 4'd9) begin
                    coef_d[kaddr] = coef_t'(kdin);
                end
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                clr    = (tap_q == 4'd0);
                if (tap_q == 4'd8) begin
                    state_d = S_DRAIN;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_DRAIN: state_d = S_EMIT;
            S_EMIT: begin
                if (out_ready) begin
                    if (r_q == LAST && c_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        tap_d   = '0;
                        if (c_q == LAST) begin
                            c_d = '0;
                            r_d = r_q + CW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        rd_d   = mem_rd;
        rtap_d = tap_q;
    end

    // Image side is a power of two, so the address is a plain concatenation
    always_comb begin
        row_a    = r_q + CW'(tap_ky(tap_q));
        col_a    = c_q + CW'(tap_kx(tap_q));
        mem_addr = (state_q == S_FETCH) ? {row_a, col_a} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            rtap_q  <= '0;
            rd_q    <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
            for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            rtap_q  <= rtap_d;
            rd_q    <= rd_d;
            r_q     <= r_d;
            c_q     <= c_d;
            coef_q  <= coef_d;
        end
    end

    conv_mac u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (rd_q),
        .pix  (pixel_t'(mem_dout)),
        .coef (coef_q[rtap_q]),
        .acc  (acc)
    );

`ifdef CONV_SAT_EN
    acc_t sh;
    always_comb begin
        sh = acc >>> FRAC_BITS;
        if (sh > acc_t'(127)) begin
            out_data = 8'h7f;
        end else if (sh < acc_t'(-128)) begin
            out_data = 8'h80;
        end else begin
            out_data = sh[7:0];
        end
    end
`else
    always_comb begin
        out_data = 8'(acc >>> FRAC_BITS);
    end
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = (state_q == S_EMIT);
    assign out_row   = r_q;
    assign out_col   = c_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed self-checking bench for conv3x3_engine (8x8 image).
// Expectations follow CONV_SAT_EN when it is defined.
module tb_conv3x3_engine;

    logic              clk = 1'b0;
    logic              rst, start, kwr, out_ready;
    logic [3:0]        kaddr;
    logic [7:0]        kdin;
    logic              busy, done, mem_rd, out_valid;
    logic [5:0]        mem_addr;
    logic signed [7:0] mem_dout, out_data;
    logic [2:0]        out_row, out_col;

    logic signed [7:0] img [64];
    logic signed [7:0] kc  [9];
    int n_chk = 0, n_err = 0, done_cnt = 0, d0 = 0;
    int sd, sr, sc;

    always #5 clk = ~clk;

    conv3x3_engine #(.IMG_DIM(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .kwr(kwr), .kaddr(kaddr), .kdin(kdin),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col)
    );

    // Image memory with one-cycle read latency
    always @(posedge clk) mem_dout <= mem_rd ? img[mem_addr] : 8'sd0;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int r, input int c);
        int acc, sh;
        logic signed [7:0] b;
        acc = 0;
        for (int k = 0; k < 9; k++)
            acc += int'(img[(r + k / 3) * 8 + c + k % 3]) * int'(kc[k]);
        sh = acc >>> 7;
`ifdef CONV_SAT_EN
        if (sh > 127) return 127;
        if (sh < -128) return -128;
        return sh;
`else
        b = 8'(sh);
        return int'(b);
`endif
    endfunction

    task automatic load_k();
        for (int k = 0; k < 9; k++) begin
            kwr = 1'b1; kaddr = 4'(k); kdin = kc[k];
            @(negedge clk);
        end
        kwr = 1'b0;
    endtask

    task automatic set_k(input int c4, input int others);
        for (int k = 0; k < 9; k++) kc[k] = 8'(others);
        kc[4] = 8'(c4);
    endtask

    task automatic fill(input int v);
        for (int a = 0; a < 64; a++) img[a] = 8'(v);
    endtask

    task automatic go();
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int nres, input bit use_model, input int cexp);
        int t;
        for (int n = 0; n < nres; n++) begin
            t = 0;
            while (!out_valid && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("valid", int'(out_valid), 1);
            chk("data", int'(out_data), use_model ? model(n / 6, n % 6) : cexp);
            chk("row", int'(out_row), n / 6);
            chk("col", int'(out_col), n % 6);
            @(negedge clk);
        end
    endtask

    task automatic fin();
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 1);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kwr = 1'b0; kaddr = '0; kdin = '0;
        out_ready = 1'b1;
        fill(0);
        set_k(0, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd", int'(mem_rd), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_row", int'(out_row), 0);
        chk("rst_col", int'(out_col), 0);
        rst = 1'b0;
        @(negedge clk);

        // Identity-like kernel, flat image, with fetch timing
        set_k(64, 0); fill(100); load_k();
        go();
        chk("c1_busy", int'(busy), 1);
        chk("c1_rd", int'(mem_rd), 1);
        chk("c1_addr", int'(mem_addr), 0);
        repeat (4) @(negedge clk);
        chk("c5_addr", int'(mem_addr), 9);
        repeat (4) @(negedge clk);
        chk("c9_addr", int'(mem_addr), 18);
        @(negedge clk);
        chk("c10_rd", int'(mem_rd), 0);
        chk("c10_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("c11_valid", int'(out_valid), 1);
        run(36, 1'b0, 50);
        fin();

        // Varied image and asymmetric kernel
        for (int a = 0; a < 64; a++) img[a] = 8'(a * 37 + 5);
        kc[0] = 3;   kc[1] = -5;  kc[2] = 7;
        kc[3] = -11; kc[4] = 64;  kc[5] = 13;
        kc[6] = -17; kc[7] = 19;  kc[8] = -23;
        load_k();
        go();
        run(36, 1'b1, 0);
        fin();

        // Positive overflow
        set_k(127, 127); fill(127); load_k();
        go();
`ifdef CONV_SAT_EN
        run(36, 1'b0, 127);
`else
        run(36, 1'b0, 110);
`endif
        fin();

        // Negative overflow
        set_k(-128, -128); load_k();
        go();
`ifdef CONV_SAT_EN
        run(36, 1'b0, -128);
`else
        run(36, 1'b0, -119);
`endif
        fin();

        // Back-pressure on the first result
        set_k(64, 0); fill(100); load_k();
        out_ready = 1'b0;
        go();
        for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
        sd = int'(out_data); sr = int'(out_row); sc = int'(out_col);
        chk("stall_first", sd, 50);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), sd);
            chk("stall_row", int'(out_row), sr);
            chk("stall_col", int'(out_col), sc);
            chk("stall_rd", int'(mem_rd), 0);
        end
        out_ready = 1'b1;
        run(36, 1'b0, 50);
        fin();

        // start and kwr while busy are ignored
        go();
        @(negedge clk);
        start = 1'b1; kwr = 1'b1; kaddr = 4'd4; kdin = 8'd1;
        @(negedge clk);
        start = 1'b0; kwr = 1'b0;
        run(36, 1'b0, 50);
        fin();

        // Reset mid-stream, then restart with cleared kernel
        go();
        run(10, 1'b0, 50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_done", int'(done), 0);
        repeat (30) @(negedge clk);
        chk("mid_rst_idle", int'(busy), 0);
        chk("mid_rst_nodone", done_cnt - d0, 0);
        go();
        run(36, 1'b0, 0);
        fin();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv3x3_engine.md
CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

Interface
REQ-001 SHALL have parameter IMG_DIM, default 8, square image side in pixels (power of two, 4..16); output side is IMG_DIM-2.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to convolve the stored image.
REQ-005 SHALL have port busy  output  1  high from the cycle after start is accepted until the done cycle.
REQ-006 SHALL have port done  output  1  one-cycle pulse after the last result is accepted.
REQ-007 SHALL have port kwr  input  1  kernel coefficient write strobe.
REQ-008 SHALL have port kaddr  input  4  tap index 0..8, where ky*3+kx; values 9..15 are ignored.
REQ-009 SHALL have port kdin  input  8  signed Q1.7 coefficient.
REQ-010 SHALL have port mem_rd  output  1  image memory read strobe.
REQ-011 SHALL have port mem_addr  output  6 (2*log2(IMG_DIM))  pixel address, row*IMG_DIM+col.
REQ-012 SHALL have port mem_dout  input  8  signed Q1.7 pixel, valid exactly one cycle after mem_rd.
REQ-013 SHALL have ports out_valid output 1, out_ready input 1, out_data output 8 (signed Q1.7), out_row output 3, out_col output 3; together they form the result stream.

Function
REQ-014 SHALL implement FSM IDLE -> FETCH -> DRAIN -> EMIT -> (FETCH | DONE) -> IDLE.
REQ-015 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-016 SHALL accept kwr only in IDLE; kwr while busy is dropped and the stored kernel is unchanged.
REQ-017 In FETCH, tap k=0..8 SHALL be issued on consecutive cycles: mem_rd=1, mem_addr=(r+ky)*IMG_DIM+(c+kx), for 9 cycles.
REQ-018 Each returned pixel SHALL be multiplied by coefficient k (signed 8x8 -> 16-bit Q2.14) and added into a 20-bit signed accumulator that is cleared at the start of every window.
REQ-019 DRAIN SHALL last 1 cycle, with mem_rd=0, and SHALL absorb the tap-8 product.
REQ-020 Result SHALL be acc >>> 7 (arithmetic shift, floor) reduced to 8 bits per REQ-031.
REQ-021 EMIT SHALL hold out_valid=1 with stable out_data, out_row=r, out_col=c until out_valid&&out_ready; mem_rd SHALL be 0 during EMIT.
REQ-022 Windows SHALL be produced in raster order, r and c each running 0..IMG_DIM-3 with c fastest; at default there are 36 results.
REQ-023 Minimum spacing SHALL be 11 cycles per result; out_valid SHALL first assert on the 11th cycle after the start-accept edge.
REQ-024 After the last handshake the FSM SHALL enter DONE for one cycle (done=1, busy=1) and then IDLE (busy=0).
REQ-025 SHALL hold out_valid, mem_rd and done low in IDLE.

Reset
REQ-026 rst SHALL force IDLE on the same edge from any state, including mid-FETCH and mid-EMIT.
REQ-027 Reset values SHALL be: busy=0, done=0, mem_rd=0, mem_addr=0, out_valid=0, out_data=0, out_row=0, out_col=0, accumulator=0, all 9 coefficients=0.
REQ-028 A reset during an operation SHALL NOT produce a done pulse.
REQ-029 rst SHALL take priority over start and kwr in the same cycle.

Configuration
REQ-030 The macro CONV_SAT_EN SHALL select the result reduction.
REQ-031 With CONV_SAT_EN defined, the shifted value SHALL be clamped to [-128,127]; without it, its low 8 bits SHALL be taken (two's-complement wrap).

Structure
REQ-032 Package conv_pkg SHALL hold FRAC_BITS=7 and the pixel_t (8-bit signed), coef_t (8-bit signed), acc_t (20-bit signed) and state_t FSM enum.
REQ-033 Sub-module conv_mac (signed 8x8 multiply, 20-bit accumulate, synchronous clear) SHALL be the single instantiated child.

Verification
REQ-034 Kernel with tap4=64 and all others 0, every pixel 100 -> 36 results of 50, rows/cols in raster order, one done.
REQ-035 All coefficients 127, all pixels 127 -> acc=145161 -> 127 with CONV_SAT_EN, 110 without.
REQ-036 All coefficients -128, all pixels 127 -> acc=-146304 -> -128 with CONV_SAT_EN, -119 without.
REQ-037 out_ready held 0 for 5 cycles on result 0 -> out_valid, out_data and coordinates stable, mem_rd=0; the stream then resumes, 36 results total.
REQ-038 rst pulsed after 10 results -> next cycle busy=0, out_valid=0, no done; a restart without kernel reload yields 36 zeros.
REQ-039 start and kwr (kaddr=4, kdin=1) asserted mid-operation -> both ignored; results match the original kernel.
